fp_div_ctrl: RTL

//   Runtime-programmable clock divider controller for the fp clock-generation path.

---
 rtl/fp_div_ctrl_pkg.sv | 20 ++
 rtl/fp_div_ctrl_if.sv | 27 ++
 rtl/fp_period_cnt.sv | 32 +++
 rtl/fp_div_ctrl.sv | 114 +++++++++++
 4 files changed

// File: rtl/fp_div_ctrl_pkg.sv
// Shared definitions for the fp clock divider controller.
//   fp_state_e  : controller state encoding (IDLE / RUN / PEND)
//   FP_MIN_DIV  : smallest divide ratio the divider can produce
//   ratio_ok()  : legality check applied to an offered divide ratio
package fp_div_ctrl_pkg;

    typedef enum logic [1:0] {
        FP_IDLE = 2'd0,
        FP_RUN  = 2'd1,
        FP_PEND = 2'd2
    } fp_state_e;

    localparam int unsigned FP_MIN_DIV = 2;

    // Ratios of 0 and 1 cannot form a period with both a high and a low phase.
    function automatic logic ratio_ok(input logic [31:0] n);
        return (n >= 32'(FP_MIN_DIV));
    endfunction

endpackage

// File: rtl/fp_div_ctrl_if.sv
// Divide-ratio configuration port (valid/ready with an error pulse).
//   cfg_valid : new ratio offered (master -> slave)
//   cfg_div   : requested ratio (master -> slave)
//   cfg_ready : ratio can be taken this cycle (slave -> master)
//   cfg_err   : 1-cycle pulse, offered ratio was illegal and dropped (slave -> master)
interface fp_div_ctrl_if #(
    parameter int CNT_W = 8
) ();
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/fp_period_cnt.sv
// Period counter for the fp clock divider.
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : force the count to zero (held while the divider is idle)
//   run        : advance the count
//   max        : current divide ratio; the count runs 0..max-1
//   cnt        : current position within the period
//   wrap       : high on the last count of the period (cnt == max-1)
module fp_period_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             run,
    input  logic [CNT_W-1:0] max,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    assign wrap = (cnt == (max - 1'b1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fp_div_ctrl.sv
// Runtime-programmable clock divider controller for the fp clock-generation path.
// Ratio changes and start/stop requests take effect only at period boundaries,
// so div_out never glitches or truncates a period.
//   clk, rst_n : clock and asynchronous active-low reset
//   en         : run request (level)
//   cfg        : divide-ratio config port (slave side)
//   div_out    : divided clock, registered
//   tick       : 1-cycle pulse on the first clk of each div_out period, registered
//   busy       : high whenever the controller is not idle
//
//   state | meaning
//   IDLE  | stopped, outputs low, counter held at 0, ratio loads directly
//   RUN   | dividing with cur_div, config accepted
//   PEND  | dividing with cur_div, pend_div waits for the wrap, config blocked
module fp_div_ctrl
    import fp_div_ctrl_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    fp_div_ctrl_if.slave  cfg,
    output logic          div_out,
    output logic          tick,
    output logic          busy
);

    fp_state_e        state, state_nxt;
    logic [CNT_W-1:0] cur_div, cur_div_nxt;
    logic [CNT_W-1:0] pend_div, pend_div_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             wrap;
    logic             xfer, load, bad;
    logic             err_q;

    fp_period_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == FP_IDLE),
        .run   (state != FP_IDLE),
        .max   (cur_div),
        .cnt   (cnt),
        .wrap  (wrap)
    );

    assign cfg.cfg_ready = (state != FP_PEND);
    assign cfg.cfg_err   = err_q;
    assign busy          = (state != FP_IDLE);

    assign xfer = cfg.cfg_valid && cfg.cfg_ready;
    assign load = xfer && ratio_ok(32'(cfg.cfg_div));
    assign bad  = xfer && !ratio_ok(32'(cfg.cfg_div));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FP_IDLE;
            cur_div  <= CNT_W'(DEF_DIV);
            pend_div <= CNT_W'(DEF_DIV);
        end else begin
            state    <= state_nxt;
            cur_div  <= cur_div_nxt;
            pend_div <= pend_div_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cur_div_nxt  = cur_div;
        pend_div_nxt = pend_div;
        case (state)
            FP_IDLE: begin
                if (load) cur_div_nxt = cfg.cfg_div;
                if (en)   state_nxt   = FP_RUN;
            end
            FP_RUN: begin
                if (wrap && !en) begin
                    // Stopping at this boundary: nothing left to defer to,
                    // so an accepted ratio goes straight into cur_div.
                    state_nxt = FP_IDLE;
                    if (load) cur_div_nxt = cfg.cfg_div;
                end else if (load) begin
                    pend_div_nxt = cfg.cfg_div;
                    state_nxt    = FP_PEND;
                end
            end
            FP_PEND: begin
                if (wrap) begin
                    cur_div_nxt = pend_div;
                    state_nxt   = en ? FP_RUN : FP_IDLE;
                end
            end
            default: state_nxt = FP_IDLE;
        endcase
    end

    // Outputs are decoded from the values the counter and ratio take on the
    // coming edge, so the registered div_out/tick line up with cnt.
    assign cnt_nxt = ((state == FP_IDLE) || wrap) ? '0 : cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_out <= 1'b0;
            tick    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            div_out <= (state_nxt != FP_IDLE) && (cnt_nxt < (cur_div_nxt >> 1));
            tick    <= (state_nxt != FP_IDLE) && (cnt_nxt == '0);
            err_q   <= bad;
        end
    end

endmodule
